// File: rtl/sid_shadow_player_if.sv
// Host write path, shadow RAM port and SID pin bundle for sid_shadow_player.
// The host/testbench side takes the master modport; the player takes the slave modport.
interface sid_shadow_player_if #(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 5
);
  logic                     host_we;
  logic [RAM_ADDR_BITS-1:0] host_addr;
  logic [RAM_WIDTH-1:0]     host_data;

  logic                     ram_we;
  logic [RAM_ADDR_BITS-1:0] ram_addr;
  logic [RAM_WIDTH-1:0]     ram_in;
  logic [RAM_WIDTH-1:0]     ram_out;

  logic                     sid_phi2;
  logic                     sid_cs_n;
  logic                     sid_rw;
  logic [RAM_ADDR_BITS-1:0] sid_addr;
  logic [RAM_WIDTH-1:0]     sid_data;
  logic                     sid_data_oe;
  logic                     busy;

  modport master (
    output host_we, host_addr, host_data, ram_out,
    input  ram_we, ram_addr, ram_in,
    input  sid_phi2, sid_cs_n, sid_rw, sid_addr, sid_data, sid_data_oe, busy
  );

  modport slave (
    input  host_we, host_addr, host_data, ram_out,
    output ram_we, ram_addr, ram_in,
    output sid_phi2, sid_cs_n, sid_rw, sid_addr, sid_data, sid_data_oe, busy
  );
endinterface

// File: rtl/sid_shadow_player.sv
// SID shadow register replayer: tracks dirty registers written by the host and replays each one
// onto the physical SID bus as a phi2-aligned write cycle, fetching from the RAM in idle cycles.
module sid_shadow_player #(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 5,
  parameter int unsigned CLK_DIV       = 8
) (
  input logic                clk,
  input logic                rst_n,
  sid_shadow_player_if.slave bus
);
  localparam int unsigned     NumRegs = 2 ** RAM_ADDR_BITS;
  localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StBus, StHold} state_e;

  state_e                   state_q, state_d;
  logic [NumRegs-1:0]       dirty_q, dirty_d;
  logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [RAM_ADDR_BITS-1:0] sel_q, sel_d;
  logic [RAM_WIDTH-1:0]     data_q, data_d;
  logic [DivW-1:0]          div_q, div_d;
  logic                     phi2_q, phi2_d;
  logic                     cs_n_q, cs_n_d;
  logic                     rw_q, rw_d;
  logic                     oe_q, oe_d;
  logic [RAM_ADDR_BITS-1:0] sid_addr_q, sid_addr_d;
  logic [RAM_WIDTH-1:0]     sid_data_q, sid_data_d;

  logic                     div_wrap;
  logic                     found;
  logic [RAM_ADDR_BITS-1:0] pick;
  logic [RAM_ADDR_BITS-1:0] cand;

  // Free-running phi2: toggles every CLK_DIV clk
  assign div_wrap = (div_q == DivMax);
  assign div_d    = div_wrap ? '0 : div_q + 1'b1;
  assign phi2_d   = div_wrap ? ~phi2_q : phi2_q;

  // First dirty register at or after the round-robin pointer, wrapping
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      cand = ptr_q + RAM_ADDR_BITS'(i);
      if (!found && dirty_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dirty_d    = dirty_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    data_d     = data_q;
    cs_n_d     = cs_n_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    sid_addr_d = sid_addr_q;
    sid_data_d = sid_data_q;

    case (state_q)
      StIdle: begin
        if (found) begin
          sel_d   = pick;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (!bus.host_we) begin
          data_d         = bus.ram_out;
          dirty_d[sel_q] = 1'b0;
          ptr_d          = sel_q + 1'b1;
          state_d        = StWait;
        end
      end
      StWait: begin
        // Launch the cycle on the edge where phi2 rises
        if (!phi2_q && div_wrap) begin
          cs_n_d     = 1'b0;
          rw_d       = 1'b0;
          oe_d       = 1'b1;
          sid_addr_d = sel_q;
          sid_data_d = data_q;
          state_d    = StBus;
        end
      end
      StBus: begin
        if (phi2_q && div_wrap) state_d = StHold;
      end
      StHold: begin
        cs_n_d  = 1'b1;
        rw_d    = 1'b1;
        oe_d    = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A host write landing on the fetch-clear edge re-arms the register
    if (bus.host_we) dirty_d[bus.host_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dirty_q    <= '0;
      ptr_q      <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      div_q      <= '0;
      phi2_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rw_q       <= 1'b1;
      oe_q       <= 1'b0;
      sid_addr_q <= '0;
      sid_data_q <= '0;
    end else begin
      state_q    <= state_d;
      dirty_q    <= dirty_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      div_q      <= div_d;
      phi2_q     <= phi2_d;
      cs_n_q     <= cs_n_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      sid_addr_q <= sid_addr_d;
      sid_data_q <= sid_data_d;
    end
  end

  assign bus.ram_we      = bus.host_we;
  assign bus.ram_in      = bus.host_data;
  assign bus.ram_addr    = bus.host_we ? bus.host_addr : sel_q;
  assign bus.sid_phi2    = phi2_q;
  assign bus.sid_cs_n    = cs_n_q;
  assign bus.sid_rw      = rw_q;
  assign bus.sid_addr    = sid_addr_q;
  assign bus.sid_data    = sid_data_q;
  assign bus.sid_data_oe = oe_q;
  assign bus.busy        = (|dirty_q) | (state_q != StIdle);
endmodule
